adc_sample_scheduler: RTL and testbench

Sequences conversions on an array of LTC2315 hydrophone ADC drivers at a fixed sample rate. It asserts each driver's enable window, collects one 12-bit sample per channel, and timestamps the sample set. It then presents the set as a single frame on a valid/ready stream toward the acoustic DSP and capture FIFO. It sits between the per-channel ADC drivers and the downstream sample pipeline, and is the only block that drives the drivers' `enable`.

---
 rtl/acoustics_pkg.sv | 23 ++
 rtl/sample_frame_reg.sv | 31 +++
 rtl/adc_sample_scheduler.sv | 130 +++++++++++++
 tb/tb_adc_sample_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acoustics_pkg.sv
// rtl/acoustics_pkg.sv - shared types and constants for the hydrophone sampling path
package acoustics_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    EMIT    = 2'd3
  } sched_state_e;

  localparam int N_CH_DEFAULT     = 4;
  localparam int ADC_DATA_W       = 12;
  localparam int ADC_FRAME_CYCLES = 18;
  localparam int FRAME_TS_W       = 32;

  // Frame layout for the default configuration; the flat frame bus uses the same order.
  typedef struct packed {
    logic [N_CH_DEFAULT-1:0]            missing;
    logic [FRAME_TS_W-1:0]              ts;
    logic [N_CH_DEFAULT*ADC_DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/sample_frame_reg.sv
// rtl/sample_frame_reg.sv - single-entry valid/ready frame register, drops new frames when full
module sample_frame_reg #(
  parameter int W = 84
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_tvalid,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic         drop
);

  // Load when empty or draining this cycle; otherwise hold the pending frame untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (s_tvalid && (!m_tvalid || m_tready)) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // A new frame arriving against a stalled full register is lost.
  assign drop = s_tvalid & m_tvalid & ~m_tready;

endmodule

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - periodic ADC capture sequencer with timestamped frame output
module adc_sample_scheduler
  import acoustics_pkg::*;
#(
  parameter int N_CH       = N_CH_DEFAULT,
  parameter int DATA_W     = ADC_DATA_W,
  parameter int SAMPLE_DIV = 100,
  parameter int TIMEOUT    = 40,
  parameter int TS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  output logic [N_CH-1:0]        adc_enable,
  input  logic [N_CH*DATA_W-1:0] adc_data,
  input  logic [N_CH-1:0]        adc_valid,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [N_CH*DATA_W-1:0] frame_data,
  output logic [TS_W-1:0]        frame_ts,
  output logic [N_CH-1:0]        frame_missing,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   busy
);

  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int FRAME_W = N_CH + TS_W + N_CH*DATA_W;

  sched_state_e           state;
  logic [TS_W-1:0]        ts_cnt;
  logic [TS_W-1:0]        ts_hold;
  logic [DIV_W-1:0]       div_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [N_CH-1:0]        done;
  logic [N_CH-1:0]        capt;
  logic [N_CH*DATA_W-1:0] sample;
  logic [N_CH*DATA_W-1:0] masked;
  logic                   tick;
  logic                   frame_drop;

  assign tick = run && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign capt = adc_valid & ~done & {N_CH{state == CAPTURE}};

  // Combinational on adc_valid so a driver freezes in the very cycle it reports its sample.
  assign adc_enable = {N_CH{state == CAPTURE}} & ~done & ~adc_valid;
  assign busy       = (state != IDLE);

  // Free-running timestamp base, independent of run.
  always_ff @(posedge clk) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  // Sample period counter, parked at 0 whenever scheduling is disabled.
  always_ff @(posedge clk) begin
    if (!reset_n || !run)                     div_cnt <= '0;
    else if (div_cnt == DIV_W'(SAMPLE_DIV-1)) div_cnt <= '0;
    else                                      div_cnt <= div_cnt + 1'b1;
  end

  // Scheduler FSM with per-channel capture latches and timeout counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ts_hold <= '0;
      tmo_cnt <= '0;
      done    <= '0;
      sample  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (capt[i]) sample[i*DATA_W +: DATA_W] <= adc_data[i*DATA_W +: DATA_W];
      end
      case (state)
        IDLE: begin
          if (run) state <= WAIT;
        end
        WAIT: begin
          if (tick) begin
            state   <= CAPTURE;
            ts_hold <= ts_cnt;
            done    <= '0;
            tmo_cnt <= '0;
          end else if (!run) begin
            state <= IDLE;
          end
        end
        CAPTURE: begin
          done    <= done | capt;
          tmo_cnt <= tmo_cnt + 1'b1;
          if ((&(done | capt)) || (tmo_cnt == TMO_W'(TIMEOUT - 1))) state <= EMIT;
        end
        EMIT: begin
          state <= run ? WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channels that never reported carry a zero sample.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (done[i]) masked[i*DATA_W +: DATA_W] = sample[i*DATA_W +: DATA_W];
    end
  end

  sample_frame_reg #(
    .W(FRAME_W)
  ) u_frame_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_tvalid (state == EMIT),
    .s_tdata  ({~done, ts_hold, masked}),
    .m_tvalid (frame_valid),
    .m_tready (frame_ready),
    .m_tdata  ({frame_missing, frame_ts, frame_data}),
    .drop     (frame_drop)
  );

  // Sticky loss flag: a dropped frame or a tick outside WAIT; setting beats clearing.
  always_ff @(posedge clk) begin
    if (!reset_n)                              overrun <= 1'b0;
    else if (frame_drop || (tick && state != WAIT)) overrun <= 1'b1;
    else if (overrun_clr)                      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb/tb_adc_sample_scheduler.sv - directed self-checking bench for adc_sample_scheduler
module tb_adc_sample_scheduler;
  import acoustics_pkg::*;

  localparam int N_CH   = 4;
  localparam int DATA_W = 12;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   run = 1'b0;
  logic                   frame_ready = 1'b1;
  logic                   overrun_clr = 1'b0;
  logic [N_CH-1:0]        adc_enable;
  logic [N_CH*DATA_W-1:0] adc_data;
  logic [N_CH-1:0]        adc_valid;
  logic                   frame_valid;
  logic [N_CH*DATA_W-1:0] frame_data;
  logic [31:0]            frame_ts;
  logic [N_CH-1:0]        frame_missing;
  logic                   overrun;
  logic                   busy;

  logic [N_CH-1:0]        adc_enable8;
  logic                   frame_valid8;
  logic [N_CH*DATA_W-1:0] frame_data8;
  logic [7:0]             frame_ts8;
  logic [N_CH-1:0]        frame_missing8;
  logic                   overrun8;
  logic                   busy8;

  logic [DATA_W-1:0] chan_val [N_CH];
  logic [N_CH-1:0]   dead = '0;
  logic [7:0]        drv_cnt [N_CH];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int en_cnt [N_CH];
  int rst_cyc = 0;
  int c0 = 0;

  localparam logic [47:0] NOM_DATA = 48'h103102101100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_sample_scheduler #(
    .N_CH(N_CH), .DATA_W(DATA_W), .SAMPLE_DIV(100), .TIMEOUT(40), .TS_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .adc_enable(adc_enable),
    .adc_data(adc_data), .adc_valid(adc_valid), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .frame_ts(frame_ts),
    .frame_missing(frame_missing), .overrun(overrun), .overrun_clr(overrun_clr),
    .busy(busy)
  );

  adc_sample_scheduler #(
    .N_CH(N_CH), .DATA_W(DATA_W), .SAMPLE_DIV(100), .TIMEOUT(40), .TS_W(8)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .run(run), .adc_enable(adc_enable8),
    .adc_data(adc_data), .adc_valid(adc_valid), .frame_valid(frame_valid8),
    .frame_ready(frame_ready), .frame_data(frame_data8), .frame_ts(frame_ts8),
    .frame_missing(frame_missing8), .overrun(overrun8), .overrun_clr(overrun_clr),
    .busy(busy8)
  );

  // Driver models: valid pulses after ADC_FRAME_CYCLES enabled cycles, then restart.
  always_comb begin
    adc_data  = '0;
    adc_valid = '0;
    for (int i = 0; i < N_CH; i++) begin
      adc_data[i*DATA_W +: DATA_W] = chan_val[i];
      adc_valid[i] = (drv_cnt[i] == 8'(ADC_FRAME_CYCLES)) && !dead[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (!reset_n)          drv_cnt[i] <= 8'd0;
      else if (adc_valid[i]) drv_cnt[i] <= 8'd0;
      else if (adc_enable[i]) drv_cnt[i] <= drv_cnt[i] + 8'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CH; i++) if (adc_enable[i]) en_cnt[i]++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset(input logic run_at_release);
    step();
    reset_n = 1'b0; run = 1'b0; frame_ready = 1'b1; overrun_clr = 1'b0; dead = '0;
    for (int i = 0; i < N_CH; i++) chan_val[i] = DATA_W'(12'h100 + i);
    repeat (3) step();
    reset_n = 1'b1;
    run = run_at_release;
    rst_cyc = cyc;
    c0 = cyc;
    for (int i = 0; i < N_CH; i++) en_cnt[i] = 0;
  endtask

  task automatic start_run();
    run = 1'b1;
    c0 = cyc;
    for (int i = 0; i < N_CH; i++) en_cnt[i] = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({adc_enable, frame_valid, frame_data, frame_ts, frame_missing, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%h fv=%b d=%h ts=%h m=%h ov=%b busy=%b expected all zero",
               adc_enable, frame_valid, frame_data, frame_ts, frame_missing, overrun, busy);
    end
    checks++;
    if ({adc_enable8, frame_valid8, frame_data8, frame_ts8, frame_missing8, overrun8, busy8} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_ts8: got en=%h fv=%b d=%h ts=%h m=%h ov=%b busy=%b expected all zero",
               adc_enable8, frame_valid8, frame_data8, frame_ts8, frame_missing8, overrun8, busy8);
    end
    repeat (5) step();
    checks++;
    if (busy !== 1'b0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_run: got busy=%b fv=%b expected 0 0", busy, frame_valid);
    end
  endtask

  task automatic test_nominal();
    do_reset(1'b0);
    step(); step();
    start_run();
    for (int n = 0; n < 3; n++) begin
      step_to(c0 + 119 + 100*n);
      checks++;
      if (frame_valid !== 1'b0) begin
        errors++; $display("FAIL nom_early_%0d: got fv=%b expected 0", n, frame_valid);
      end
      step();
      checks++;
      if (frame_valid !== 1'b1 || frame_data !== NOM_DATA || frame_missing !== 4'b0000 ||
          frame_ts !== 32'(c0 + 99 + 100*n - rst_cyc)) begin
        errors++;
        $display("FAIL nom_frame_%0d: got fv=%b d=%h m=%b ts=%0d expected 1 %h 0000 %0d",
                 n, frame_valid, frame_data, frame_missing, frame_ts, NOM_DATA,
                 c0 + 99 + 100*n - rst_cyc);
      end
      step();
      checks++;
      if (frame_valid !== 1'b0) begin
        errors++; $display("FAIL nom_single_beat_%0d: got fv=%b expected 0", n, frame_valid);
      end
    end
  endtask

  task automatic test_enable_gating();
    do_reset(1'b0);
    start_run();
    step_to(c0 + 100);
    checks++;
    if (adc_enable !== 4'hF || busy !== 1'b1) begin
      errors++; $display("FAIL gate_enable_rise: got en=%h busy=%b expected f 1", adc_enable, busy);
    end
    step_to(c0 + 117);
    checks++;
    if (adc_enable !== 4'hF || adc_valid !== 4'h0) begin
      errors++; $display("FAIL gate_before_valid: got en=%h v=%h expected f 0", adc_enable, adc_valid);
    end
    step();
    checks++;
    if (adc_enable !== 4'h0 || adc_valid !== 4'hF) begin
      errors++; $display("FAIL gate_on_valid: got en=%h v=%h expected 0 f", adc_enable, adc_valid);
    end
    step_to(c0 + 199);
    checks++;
    if (en_cnt[0] !== 18 || en_cnt[3] !== 18) begin
      errors++; $display("FAIL gate_enable_count: got %0d %0d expected 18 18", en_cnt[0], en_cnt[3]);
    end
    step_to(c0 + 217);
    checks++;
    if (adc_enable !== 4'hF || adc_valid !== 4'h0) begin
      errors++; $display("FAIL gate2_before_valid: got en=%h v=%h expected f 0", adc_enable, adc_valid);
    end
    step();
    checks++;
    if (adc_enable !== 4'h0 || adc_valid !== 4'hF) begin
      errors++; $display("FAIL gate2_on_valid: got en=%h v=%h expected 0 f", adc_enable, adc_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    start_run();
    step_to(c0 + 150);
    dead = 4'b0100;
    chan_val[0] = 12'hA5A; chan_val[1] = 12'h3C3; chan_val[2] = 12'hFFF; chan_val[3] = 12'h001;
    for (int i = 0; i < N_CH; i++) en_cnt[i] = 0;
    step_to(c0 + 240);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_early: got fv=%b busy=%b expected 0 1", frame_valid, busy);
    end
    step();
    checks++;
    if (frame_valid !== 1'b1 || frame_missing !== 4'b0100 || frame_data !== 48'h0010003C3A5A ||
        frame_ts !== 32'(c0 + 199 - rst_cyc)) begin
      errors++;
      $display("FAIL tmo_frame: got fv=%b m=%b d=%h ts=%0d expected 1 0100 0010003c3a5a %0d",
               frame_valid, frame_missing, frame_data, frame_ts, c0 + 199 - rst_cyc);
    end
    step_to(c0 + 299);
    checks++;
    if (en_cnt[2] !== 40 || en_cnt[0] !== 18) begin
      errors++; $display("FAIL tmo_enable_count: got ch2=%0d ch0=%0d expected 40 18", en_cnt[2], en_cnt[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    frame_ready = 1'b0;
    start_run();
    step_to(c0 + 120);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== NOM_DATA || frame_ts !== 32'(c0 + 99 - rst_cyc) ||
        overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got fv=%b d=%h ts=%0d ov=%b expected 1 %h %0d 0",
               frame_valid, frame_data, frame_ts, overrun, NOM_DATA, c0 + 99 - rst_cyc);
    end
    step_to(c0 + 220);
    checks++;
    if (overrun !== 1'b1 || frame_ts !== 32'(c0 + 99 - rst_cyc)) begin
      errors++;
      $display("FAIL bp_drop1: got ov=%b ts=%0d expected 1 %0d", overrun, frame_ts, c0 + 99 - rst_cyc);
    end
    step_to(c0 + 319);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL bp_set_wins: got ov=%b expected 1", overrun);
    end
    step_to(c0 + 370);
    checks++;
    if (frame_valid !== 1'b1 || frame_data !== NOM_DATA || frame_ts !== 32'(c0 + 99 - rst_cyc)) begin
      errors++;
      $display("FAIL bp_held: got fv=%b d=%h ts=%0d expected 1 %h %0d",
               frame_valid, frame_data, frame_ts, NOM_DATA, c0 + 99 - rst_cyc);
    end
    frame_ready = 1'b1;
    step();
    checks++;
    if (frame_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++; $display("FAIL bp_transfer: got fv=%b ov=%b expected 0 1", frame_valid, overrun);
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL bp_clear: got ov=%b expected 0", overrun);
    end
    step_to(c0 + 420);
    checks++;
    if (frame_valid !== 1'b1 || frame_ts !== 32'(c0 + 399 - rst_cyc)) begin
      errors++;
      $display("FAIL bp_resume: got fv=%b ts=%0d expected 1 %0d", frame_valid, frame_ts, c0 + 399 - rst_cyc);
    end
  endtask

  task automatic test_run_drop();
    do_reset(1'b0);
    start_run();
    step_to(c0 + 105);
    run = 1'b0;
    step_to(c0 + 119);
    checks++;
    if (busy !== 1'b1 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL rundrop_emit: got busy=%b fv=%b expected 1 0", busy, frame_valid);
    end
    step();
    checks++;
    if (frame_valid !== 1'b1 || busy !== 1'b0 || frame_data !== NOM_DATA) begin
      errors++;
      $display("FAIL rundrop_frame: got fv=%b busy=%b d=%h expected 1 0 %h", frame_valid, busy, frame_data, NOM_DATA);
    end
    step_to(c0 + 260);
    checks++;
    if (frame_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rundrop_quiet: got fv=%b busy=%b ov=%b expected 0 0 0", frame_valid, busy, overrun);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    frame_ready = 1'b0;
    start_run();
    step_to(c0 + 130);
    checks++;
    if (frame_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pending: got fv=%b busy=%b expected 1 1", frame_valid, busy);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if ({adc_enable, frame_valid, frame_data, frame_ts, frame_missing, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got en=%h fv=%b d=%h ts=%h m=%h ov=%b busy=%b expected all zero",
               adc_enable, frame_valid, frame_data, frame_ts, frame_missing, overrun, busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_ts_wrap();
    logic [7:0] exp_ts [3];
    exp_ts[0] = 8'd99; exp_ts[1] = 8'd199; exp_ts[2] = 8'd43;
    do_reset(1'b1);
    for (int n = 0; n < 3; n++) begin
      step_to(c0 + 120 + 100*n);
      checks++;
      if (frame_valid8 !== 1'b1 || frame_ts8 !== exp_ts[n]) begin
        errors++;
        $display("FAIL ts_wrap_%0d: got fv=%b ts=%0d expected 1 %0d", n, frame_valid8, frame_ts8, exp_ts[n]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N_CH; i++) chan_val[i] = '0;
    test_reset();
    test_nominal();
    test_enable_gating();
    test_timeout();
    test_backpressure();
    test_run_drop();
    test_reset_mid();
    test_ts_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
